fc_1: RTL and testbench

- First fully connected layer of the LeNet datapath. Sits directly downstream of pool_2.
- Reads the 50x4x4 = 800 pooled activations that pool_2 leaves in the shared result BRAM, starting at 17600.
- For each output neuron, multiply-accumulates the activations against signed weights from a dedicated weight BRAM and adds a per-neuron bias.
- Requantizes with ReLU and saturation, then writes one 8-bit result per neuron back into the result BRAM.

---
 rtl/fc_1.sv | 244 ++++++++++++++++++++++++
 tb/tb_fc_1.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_1.sv
// LeNet fc_1: 800-input fully connected layer reading pooled activations from the shared
// result BRAM, MAC against weight BRAM, bias add, ReLU/saturate requantization, write back.
module fc_1 #(
    parameter int IN_LEN            = 800,
    parameter int OUT_LEN           = 500,
    parameter int DATA_SIZE         = 8,
    parameter int ACC_WIDTH         = 32,
    parameter int SHIFT             = 7,
    parameter int POOL2_RESULT_BASE = 17600,
    parameter int FC1_RESULT_BASE   = 18400,
    parameter int BIAS_BASE         = 400000,
    parameter int WADDR_WIDTH       = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fc_1_en,
    input  logic [DATA_SIZE-1:0]   result_bram_douta,
    output logic                   result_bram_ena,
    output logic                   result_bram_wea,
    output logic [14:0]            result_bram_addra,
    output logic [DATA_SIZE-1:0]   result_bram_dina,
    input  logic [DATA_SIZE-1:0]   weight_bram_douta,
    output logic                   weight_bram_ena,
    output logic [WADDR_WIDTH-1:0] weight_bram_addra,
    output logic                   fc_1_finish
);

    localparam int RADDR_WIDTH = 15;
    localparam int NW = $clog2(OUT_LEN + 1);
    localparam int IW = $clog2(IN_LEN + 1);
    localparam logic signed [ACC_WIDTH-1:0] QMAX = ACC_WIDTH'((2 ** (DATA_SIZE - 1)) - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_BIAS  = 3'd2;
    localparam logic [2:0] S_MAC   = 3'd3;
    localparam logic [2:0] S_QUANT = 3'd4;
    localparam logic [2:0] S_STORE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // ReLU then clamp to the positive range of a DATA_SIZE signed value.
    function automatic logic [DATA_SIZE-1:0] requant(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0] q;
        q = acc >>> SHIFT;
        if (q[ACC_WIDTH-1]) begin
            requant = {DATA_SIZE{1'b0}};
        end else if (q > QMAX) begin
            requant = QMAX[DATA_SIZE-1:0];
        end else begin
            requant = q[DATA_SIZE-1:0];
        end
    endfunction

    logic [2:0]                    state_q, state_d;
    logic [1:0]                    phase_q, phase_d;
    logic [NW-1:0]                 neuron_q, neuron_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_SIZE-1:0]          res_q, res_d;
    logic                          r_ena_q, r_ena_d;
    logic                          r_wea_q, r_wea_d;
    logic [RADDR_WIDTH-1:0]        r_addr_q, r_addr_d;
    logic [DATA_SIZE-1:0]          r_din_q, r_din_d;
    logic                          w_ena_q, w_ena_d;
    logic [WADDR_WIDTH-1:0]        w_addr_q, w_addr_d;
    logic                          finish_q, finish_d;

    logic signed [2*DATA_SIZE-1:0] prod_s;
    logic signed [ACC_WIDTH-1:0]   prod_ext_s;
    logic signed [ACC_WIDTH-1:0]   bias_ext_s;
    logic [RADDR_WIDTH-1:0]        act_addr_s;
    logic [RADDR_WIDTH-1:0]        out_addr_s;
    logic [WADDR_WIDTH-1:0]        wt_addr_s;
    logic [WADDR_WIDTH-1:0]        bias_addr_s;

    assign prod_s = $signed({{DATA_SIZE{result_bram_douta[DATA_SIZE-1]}}, result_bram_douta})
                  * $signed({{DATA_SIZE{weight_bram_douta[DATA_SIZE-1]}}, weight_bram_douta});
    assign prod_ext_s = {{(ACC_WIDTH-2*DATA_SIZE){prod_s[2*DATA_SIZE-1]}}, prod_s};
    assign bias_ext_s = {{(ACC_WIDTH-DATA_SIZE){weight_bram_douta[DATA_SIZE-1]}}, weight_bram_douta};

    assign act_addr_s  = RADDR_WIDTH'(POOL2_RESULT_BASE + int'(idx_q));
    assign out_addr_s  = RADDR_WIDTH'(FC1_RESULT_BASE + int'(neuron_q));
    assign wt_addr_s   = WADDR_WIDTH'(int'(neuron_q) * IN_LEN + int'(idx_q));
    assign bias_addr_s = WADDR_WIDTH'(BIAS_BASE + int'(neuron_q));

    // Next-state, datapath and BRAM-port logic; each access spends phases 0..3.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        neuron_d = neuron_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        res_d    = res_q;
        r_ena_d  = r_ena_q;
        r_wea_d  = r_wea_q;
        r_addr_d = r_addr_q;
        r_din_d  = r_din_q;
        w_ena_d  = w_ena_q;
        w_addr_d = w_addr_q;
        finish_d = finish_q;

        case (state_q)
            S_IDLE: begin
                neuron_d = {NW{1'b0}};
                idx_d    = {IW{1'b0}};
                phase_d  = 2'd0;
                finish_d = 1'b0;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                if (neuron_q == NW'(OUT_LEN)) begin
                    finish_d = 1'b1;
                    r_ena_d  = 1'b0;
                    w_ena_d  = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    idx_d   = {IW{1'b0}};
                    phase_d = 2'd0;
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0: begin
                        w_ena_d  = 1'b1;
                        w_addr_d = bias_addr_s;
                    end
                    2'd3: begin
                        acc_d   = bias_ext_s <<< SHIFT;
                        state_d = S_MAC;
                    end
                    default: begin
                        phase_d = phase_q + 2'd1;
                    end
                endcase
            end
            S_MAC: begin
                if ((phase_q == 2'd0) && (idx_q == IW'(IN_LEN))) begin
                    r_ena_d = 1'b0;
                    w_ena_d = 1'b0;
                    phase_d = 2'd0;
                    state_d = S_QUANT;
                end else begin
                    phase_d = phase_q + 2'd1;
                    case (phase_q)
                        2'd0: begin
                            r_ena_d  = 1'b1;
                            r_wea_d  = 1'b0;
                            r_addr_d = act_addr_s;
                            w_ena_d  = 1'b1;
                            w_addr_d = wt_addr_s;
                        end
                        2'd3: begin
                            acc_d = acc_q + prod_ext_s;
                            idx_d = idx_q + IW'(1);
                        end
                        default: begin
                            phase_d = phase_q + 2'd1;
                        end
                    endcase
                end
            end
            S_QUANT: begin
                res_d   = requant(acc_q);
                phase_d = 2'd0;
                state_d = S_STORE;
            end
            S_STORE: begin
                phase_d = phase_q + 2'd1;
                case (phase_q)
                    2'd0: begin
                        r_ena_d  = 1'b1;
                        r_wea_d  = 1'b1;
                        r_addr_d = out_addr_s;
                        r_din_d  = res_q;
                    end
                    2'd3: begin
                        r_ena_d  = 1'b0;
                        r_wea_d  = 1'b0;
                        neuron_d = neuron_q + NW'(1);
                        state_d  = S_CHECK;
                    end
                    default: begin
                        phase_d = phase_q + 2'd1;
                    end
                endcase
            end
            S_DONE: begin
                if (!fc_1_en) begin
                    finish_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; a low enable pauses everything except the DONE release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            phase_q  <= 2'd0;
            neuron_q <= {NW{1'b0}};
            idx_q    <= {IW{1'b0}};
            acc_q    <= {ACC_WIDTH{1'b0}};
            res_q    <= {DATA_SIZE{1'b0}};
            r_ena_q  <= 1'b0;
            r_wea_q  <= 1'b0;
            r_addr_q <= {RADDR_WIDTH{1'b0}};
            r_din_q  <= {DATA_SIZE{1'b0}};
            w_ena_q  <= 1'b0;
            w_addr_q <= {WADDR_WIDTH{1'b0}};
            finish_q <= 1'b0;
        end else if (fc_1_en || (state_q == S_DONE)) begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            neuron_q <= neuron_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            r_ena_q  <= r_ena_d;
            r_wea_q  <= r_wea_d;
            r_addr_q <= r_addr_d;
            r_din_q  <= r_din_d;
            w_ena_q  <= w_ena_d;
            w_addr_q <= w_addr_d;
            finish_q <= finish_d;
        end
    end

    assign result_bram_ena   = r_ena_q;
    assign result_bram_wea   = r_wea_q;
    assign result_bram_addra = r_addr_q;
    assign result_bram_dina  = r_din_q;
    assign weight_bram_ena   = w_ena_q;
    assign weight_bram_addra = w_addr_q;
    assign fc_1_finish       = finish_q;

endmodule

// File: tb/tb_fc_1.sv
// Directed bench for fc_1 in a reduced configuration (IN_LEN=4, OUT_LEN=2, SHIFT=2)
// with behavioural one-cycle-latency BRAM models.
module tb_fc_1;

    localparam int IN_LEN  = 4;
    localparam int OUT_LEN = 2;
    localparam int P2_BASE = 17600;
    localparam int F1_BASE = 18400;
    localparam int B_BASE  = 400000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fc_1_en;
    logic [7:0]  r_dout;
    logic        result_bram_ena;
    logic        result_bram_wea;
    logic [14:0] result_bram_addra;
    logic [7:0]  result_bram_dina;
    logic [7:0]  w_dout;
    logic        weight_bram_ena;
    logic [18:0] weight_bram_addra;
    logic        fc_1_finish;
    logic [45:0] outs_s;

    int total = 0;
    int bad   = 0;

    logic [7:0] act_mem [0:IN_LEN-1];
    logic [7:0] w_mem   [0:IN_LEN*OUT_LEN-1];
    logic [7:0] b_mem   [0:OUT_LEN-1];
    logic [7:0] out_mem [0:OUT_LEN-1];
    int wea_cycles   = 0;
    int write_count  = 0;
    int stray_writes = 0;
    bit wea_prev     = 1'b0;

    fc_1 #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .SHIFT(2)) dut (
        .clk(clk), .rst(rst), .fc_1_en(fc_1_en),
        .result_bram_douta(r_dout), .result_bram_ena(result_bram_ena),
        .result_bram_wea(result_bram_wea), .result_bram_addra(result_bram_addra),
        .result_bram_dina(result_bram_dina), .weight_bram_douta(w_dout),
        .weight_bram_ena(weight_bram_ena), .weight_bram_addra(weight_bram_addra),
        .fc_1_finish(fc_1_finish)
    );

    always #5 clk = ~clk;

    assign outs_s = {result_bram_ena, result_bram_wea, result_bram_addra, result_bram_dina,
                     weight_bram_ena, weight_bram_addra, fc_1_finish};

    function automatic logic [7:0] act_rd(input logic [14:0] a);
        int i;
        i = int'(a) - P2_BASE;
        if (i >= 0 && i < IN_LEN) return act_mem[i];
        return 8'h00;
    endfunction

    function automatic logic [7:0] w_rd(input logic [18:0] a);
        int i;
        i = int'(a);
        if (i < IN_LEN*OUT_LEN) return w_mem[i];
        if (i >= B_BASE && i < B_BASE + OUT_LEN) return b_mem[i - B_BASE];
        return 8'h00;
    endfunction

    function automatic int out_idx(input logic [14:0] a);
        return int'(a) - F1_BASE;
    endfunction

    // BRAM models plus a write monitor on the result port.
    always @(posedge clk) begin
        if (result_bram_ena && !result_bram_wea) r_dout <= act_rd(result_bram_addra);
        if (weight_bram_ena) w_dout <= w_rd(weight_bram_addra);
        if (result_bram_wea) begin
            wea_cycles <= wea_cycles + 1;
            if (!wea_prev) write_count <= write_count + 1;
            if (result_bram_ena && out_idx(result_bram_addra) >= 0 && out_idx(result_bram_addra) < OUT_LEN)
                out_mem[out_idx(result_bram_addra)] <= result_bram_dina;
            else
                stray_writes <= stray_writes + 1;
        end
        wea_prev <= result_bram_wea;
    end

    task automatic set_acts(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
        act_mem[0] = a0; act_mem[1] = a1; act_mem[2] = a2; act_mem[3] = a3;
    endtask

    task automatic set_neuron(input int n, input logic [7:0] w0, input logic [7:0] w1,
                              input logic [7:0] w2, input logic [7:0] w3, input logic [7:0] b);
        w_mem[n*IN_LEN+0] = w0; w_mem[n*IN_LEN+1] = w1;
        w_mem[n*IN_LEN+2] = w2; w_mem[n*IN_LEN+3] = w3;
        b_mem[n] = b;
    endtask

    task automatic load_basic();
        set_acts(8'd1, 8'd2, 8'd3, 8'd4);
        set_neuron(0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0);
        set_neuron(1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'd0);
    endtask

    task automatic do_reset();
        fc_1_en = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Raise enable and count cycles until finish; optional 10-cycle pause after cycle pause_at.
    task automatic run(input int pause_at, input int limit, output int fin, output int frozen_diff);
        logic [45:0] snap;
        fin = -1;
        frozen_diff = 0;
        fc_1_en = 1'b1;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk);
            #1;
            if (fc_1_finish === 1'b1) begin
                fin = c;
                break;
            end
            if (c == pause_at) begin
                fc_1_en = 1'b0;
                snap = outs_s;
                repeat (10) begin
                    @(posedge clk);
                    #1;
                    if (outs_s !== snap) frozen_diff++;
                end
                c = c + 10;
                fc_1_en = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fc_1_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        total++;
        if (outs_s !== 46'd0) begin
            bad++; $display("FAIL reset_async: outputs got %h expected 0", outs_s);
        end
        fc_1_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (outs_s !== 46'd0) begin
            bad++; $display("FAIL reset_held: outputs got %h expected 0", outs_s);
        end
        fc_1_en = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (outs_s !== 46'd0) begin
            bad++; $display("FAIL reset_idle_paused: outputs got %h expected 0", outs_s);
        end
    endtask

    task automatic test_basic_mac();
        int fin, fd, w0, c0, s0;
        do_reset();
        load_basic();
        w0 = write_count; c0 = wea_cycles; s0 = stray_writes;
        run(0, 200, fin, fd);
        total++;
        if (fin != 56) begin
            bad++; $display("FAIL basic_latency: finish cycle got %0d expected 56", fin);
        end
        total++;
        if (out_mem[0] !== 8'd2) begin
            bad++; $display("FAIL basic_n0: got %0d expected 2", out_mem[0]);
        end
        total++;
        if (out_mem[1] !== 8'd0) begin
            bad++; $display("FAIL basic_n1: got %0d expected 0", out_mem[1]);
        end
        total++;
        if (write_count - w0 != 2) begin
            bad++; $display("FAIL basic_writes: got %0d expected 2", write_count - w0);
        end
        total++;
        if (wea_cycles - c0 != 6) begin
            bad++; $display("FAIL basic_wea_cycles: got %0d expected 6", wea_cycles - c0);
        end
        total++;
        if (stray_writes != s0) begin
            bad++; $display("FAIL basic_stray: got %0d expected 0", stray_writes - s0);
        end
    endtask

    task automatic test_saturation();
        int fin, fd;
        do_reset();
        set_acts(8'd127, 8'd127, 8'd127, 8'd127);
        set_neuron(0, 8'd127, 8'd127, 8'd127, 8'd127, 8'd0);
        set_neuron(1, 8'h81, 8'h81, 8'h81, 8'h81, 8'd0);
        run(0, 200, fin, fd);
        total++;
        if (out_mem[0] !== 8'd127) begin
            bad++; $display("FAIL sat_high: got %0d expected 127", out_mem[0]);
        end
        total++;
        if (out_mem[1] !== 8'd0) begin
            bad++; $display("FAIL sat_relu: got %0d expected 0", out_mem[1]);
        end
    endtask

    task automatic test_bias();
        int fin, fd;
        do_reset();
        set_acts(8'd1, 8'd2, 8'd3, 8'd4);
        set_neuron(0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd3);
        set_neuron(1, 8'd2, 8'd0, 8'hFF, 8'd1, 8'd1);
        run(0, 200, fin, fd);
        total++;
        if (out_mem[0] !== 8'd5) begin
            bad++; $display("FAIL bias_n0: got %0d expected 5", out_mem[0]);
        end
        total++;
        if (out_mem[1] !== 8'd1) begin
            bad++; $display("FAIL bias_n1: got %0d expected 1", out_mem[1]);
        end
    endtask

    task automatic test_pause();
        int fin, fd, w0;
        do_reset();
        load_basic();
        w0 = write_count;
        run(12, 200, fin, fd);
        total++;
        if (fd != 0) begin
            bad++; $display("FAIL pause_frozen: changed cycles got %0d expected 0", fd);
        end
        total++;
        if (fin != 66) begin
            bad++; $display("FAIL pause_latency: finish cycle got %0d expected 66", fin);
        end
        total++;
        if (out_mem[0] !== 8'd2 || out_mem[1] !== 8'd0 || write_count - w0 != 2) begin
            bad++; $display("FAIL pause_results: got %0d,%0d writes %0d expected 2,0 writes 2",
                            out_mem[0], out_mem[1], write_count - w0);
        end
    endtask

    task automatic test_reset_mid_run();
        int fin, fd, w0;
        do_reset();
        load_basic();
        w0 = write_count;
        fc_1_en = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        total++;
        if (result_bram_ena !== 1'b1 || weight_bram_ena !== 1'b1) begin
            bad++; $display("FAIL midrun_active: ena got %b/%b expected 1/1", result_bram_ena, weight_bram_ena);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (outs_s !== 46'd0) begin
            bad++; $display("FAIL midrun_async_clear: outputs got %h expected 0", outs_s);
        end
        total++;
        if (write_count - w0 != 1) begin
            bad++; $display("FAIL midrun_partial_writes: got %0d expected 1", write_count - w0);
        end
        fc_1_en = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        w0 = write_count;
        run(0, 200, fin, fd);
        total++;
        if (fin != 56 || out_mem[0] !== 8'd2 || out_mem[1] !== 8'd0 || write_count - w0 != 2) begin
            bad++; $display("FAIL midrun_rerun: fin %0d res %0d,%0d writes %0d expected 56 2,0 2",
                            fin, out_mem[0], out_mem[1], write_count - w0);
        end
    endtask

    task automatic test_finish_handshake();
        int fin, fd, w0, idle_bad;
        do_reset();
        load_basic();
        run(0, 200, fin, fd);
        idle_bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (fc_1_finish !== 1'b1 || result_bram_ena !== 1'b0 ||
                result_bram_wea !== 1'b0 || weight_bram_ena !== 1'b0) idle_bad++;
        end
        total++;
        if (idle_bad != 0) begin
            bad++; $display("FAIL done_hold: bad cycles got %0d expected 0", idle_bad);
        end
        fc_1_en = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (fc_1_finish !== 1'b0) begin
            bad++; $display("FAIL done_release: finish got %b expected 0", fc_1_finish);
        end
        repeat (3) @(posedge clk);
        #1;
        set_acts(8'd127, 8'd127, 8'd127, 8'd127);
        set_neuron(0, 8'd127, 8'd127, 8'd127, 8'd127, 8'd0);
        set_neuron(1, 8'h81, 8'h81, 8'h81, 8'h81, 8'd0);
        w0 = write_count;
        run(0, 200, fin, fd);
        total++;
        if (fin != 56 || out_mem[0] !== 8'd127 || out_mem[1] !== 8'd0 || write_count - w0 != 2) begin
            bad++; $display("FAIL restart_run: fin %0d res %0d,%0d writes %0d expected 56 127,0 2",
                            fin, out_mem[0], out_mem[1], write_count - w0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_mac();
        test_saturation();
        test_bias();
        test_pause();
        test_reset_mid_run();
        test_finish_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
